// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation search controller.
package sar_pkg;

  localparam int unsigned DefaultWidth  = 16;
  localparam int unsigned DefaultSettle = 2;
  localparam int unsigned CntW          = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StVerify,
    StDone
  } state_e;

endpackage

// File: rtl/sar_search16.sv
// Successive-approximation search: recovers comparator input a by driving probes on input b.
// Optional early exit on an exact match is enabled by defining SAR_EARLY_EXIT_EN.
module sar_search16
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned SETTLE = DefaultSettle
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             agreat,
  input  logic             bgreat,
  input  logic             equal,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found
);

  localparam int unsigned     IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] Msb    = One << (WIDTH - 1);
  localparam logic [CntW-1:0]  LastCnt = CntW'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;

  logic             slot_end;
  logic [WIDTH-1:0] kept;
  logic [IdxW-1:0]  idx_dec;

  assign slot_end = (cnt_q == LastCnt);
  // Probe always equals acc | trial bit during SEARCH, so keeping the bit means taking the probe.
  assign kept     = bgreat ? acc_q : probe_q;
  assign idx_dec  = idx_q - IdxW'(1);

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          probe_d = Msb;
          acc_d   = '0;
          idx_d   = IdxW'(WIDTH - 1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          found_d = 1'b0;
          state_d = StSearch;
        end
      end
      StSearch: begin
        if (!slot_end) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d = '0;
          acc_d = kept;
          if (idx_q != '0) begin
            idx_d   = idx_dec;
            probe_d = kept | (One << idx_dec);
          end else begin
            probe_d = kept;
            state_d = StVerify;
          end
`ifdef SAR_EARLY_EXIT_EN
          if (equal) begin
            probe_d  = probe_q;
            result_d = probe_q;
            found_d  = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = StDone;
          end
`endif
        end
      end
      StVerify: begin
        if (!slot_end) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d    = '0;
          result_d = acc_q;
          found_d  = equal & ~agreat & ~bgreat;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      probe_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign found  = found_q;

endmodule

// File: tb/tb_sar_search16.sv
// Scoreboard bench for sar_search16: a behavioural comparator feeds the flags back from probe.
module tb_sar_search16;

  typedef struct {
    logic [15:0] res;
    logic        fnd;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, start1 = 1'b0;
  logic [15:0] target = '0, target1 = '0;
  logic        broken = 1'b0;

  logic        agreat, bgreat, equal;
  logic [15:0] probe, result;
  logic        busy, done, found;
  logic        agreat1, bgreat1, equal1;
  logic [15:0] probe1, result1;
  logic        busy1, done1, found1;

  int compared = 0;
  int mismatched = 0;
  int edge_n = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  // Comparator models; "broken" ties all flags of the main instance low.
  assign agreat  = !broken && (target > probe);
  assign bgreat  = !broken && (probe > target);
  assign equal   = !broken && (probe == target);
  assign agreat1 = target1 > probe1;
  assign bgreat1 = probe1 > target1;
  assign equal1  = probe1 == target1;

  sar_search16 #(.WIDTH(16), .SETTLE(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .agreat (agreat),
    .bgreat (bgreat),
    .equal  (equal),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found)
  );

  sar_search16 #(.WIDTH(16), .SETTLE(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .start  (start1),
    .agreat (agreat1),
    .bgreat (bgreat1),
    .equal  (equal1),
    .probe  (probe1),
    .busy   (busy1),
    .done   (done1),
    .result (result1),
    .found  (found1)
  );

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the SETTLE=2 instance.
  logic prev_busy0 = 1'b0, prev_done0 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_done0) check("done0_pulse", int'(done), 0);
    if (done) begin
      if (q0.size() == 0) begin
        check("done0_unexpected", 1, 0);
      end else begin
        e = q0.pop_front();
        check("result0", int'(result), int'(e.res));
        check("found0", int'(found), int'(e.fnd));
        check("latency0", edge_n - e.acc, e.lat);
        check("busy0_before_done", int'(prev_busy0), 1);
        check("busy0_at_done", int'(busy), 0);
      end
    end
    prev_busy0 = busy;
    prev_done0 = done;
  end

  // Monitor for the SETTLE=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      if (q1.size() == 0) begin
        check("done1_unexpected", 1, 0);
      end else begin
        e = q1.pop_front();
        check("result1", int'(result1), int'(e.res));
        check("found1", int'(found1), int'(e.fnd));
        check("latency1", edge_n - e.acc, e.lat);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      check({name, "_timeout"}, 1, 0);
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Start a run; optionally re-pulse start so it is sampled at edge restart_at.
  task automatic run(input string name, input logic [15:0] a, input logic [15:0] res,
                     input logic fnd, input int lat, input int restart_at);
    exp_t e;
    target = a;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.res = res;
    e.fnd = fnd;
    e.lat = lat;
    e.acc = edge_n;
    q0.push_back(e);
    if (restart_at > 0) begin
      while (edge_n != e.acc + restart_at - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain(name);
  endtask

  initial begin
    exp_t e;
    int acc;
    #1;
    check("rst_probe", int'(probe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_found", int'(found), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run("zero", 16'h0000, 16'h0000, 1'b1, 34, 0);
    run("ones", 16'hFFFF, 16'hFFFF, 1'b1, 34, 0);
    run("a30", 16'd30, 16'd30, 1'b1, 34, 0);
    run("a29", 16'd29, 16'd29, 1'b1, 34, 0);
    run("a31", 16'd31, 16'd31, 1'b1, 34, 0);
`ifdef SAR_EARLY_EXIT_EN
    run("msb", 16'h8000, 16'h8000, 1'b1, 2, 0);
`else
    run("msb", 16'h8000, 16'h8000, 1'b1, 34, 0);
`endif
    broken = 1'b1;
    run("broken", 16'h1234, 16'hFFFF, 1'b0, 34, 0);
    broken = 1'b0;
    run("restart", 16'h1234, 16'h1234, 1'b1, 34, 10);

    // Reset in the middle of a run.
    target = 16'h5A5A;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = edge_n;
    while (edge_n != acc + 11) @(negedge clk);
    check("mid_busy", int'(busy), 1);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_probe", int'(probe), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_result", int'(result), 0);
    check("mid_rst_found", int'(found), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run("after_rst", 16'h00A5, 16'h00A5, 1'b1, 34, 0);

    // SETTLE=1 instance.
    target1 = 16'h1234;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    e.res = 16'h1234;
    e.fnd = 1'b1;
    e.lat = 17;
    e.acc = edge_n;
    q1.push_back(e);
    wait_drain("settle1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
